// File: rtl/ula_pkg.sv
// ============================================================================
// Module   : ula_pkg
// Purpose  : Shared state encoding, alu_ctl field layout and named control
//            codes for the bit-serial ALU wrapper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ula_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int c_ctl_ainv  = 3;
    localparam int c_ctl_bneg  = 2;
    localparam int c_ctl_op_hi = 1;
    localparam int c_ctl_op_lo = 0;

    localparam logic [1:0] c_op_and = 2'b00;
    localparam logic [1:0] c_op_or  = 2'b01;
    localparam logic [1:0] c_op_add = 2'b10;
    localparam logic [1:0] c_op_slt = 2'b11;

    localparam logic [3:0] ULA_AND = 4'b0000;
    localparam logic [3:0] ULA_OR  = 4'b0001;
    localparam logic [3:0] ULA_ADD = 4'b0010;
    localparam logic [3:0] ULA_SUB = 4'b0110;
    localparam logic [3:0] ULA_SLT = 4'b0111;
    localparam logic [3:0] ULA_NOR = 4'b1100;

    function automatic logic [1:0] ctl_op(input logic [3:0] ctl);
        return ctl[c_ctl_op_hi:c_ctl_op_lo];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ula_serial_if.sv
// ============================================================================
// Module   : ula_serial_if
// Purpose  : Request/response handshake bundle for the bit-serial ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ula_serial_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport master (
        output in_valid, alu_ctl, a, b, out_ready,
        input  in_ready, out_valid, result, zero, overflow, carry_out
    );

    modport slave (
        input  in_valid, alu_ctl, a, b, out_ready,
        output in_ready, out_valid, result, zero, overflow, carry_out
    );
endinterface

`default_nettype wire

// File: rtl/ula_bit_cell.sv
// ============================================================================
// Module   : ula_bit_cell
// Purpose  : Combinational 1-bit ALU slice (AND/OR/ADD/less select).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_bit_cell
    import ula_pkg::*;
(
    input  logic       ai,
    input  logic       bi,
    input  logic       cin,
    input  logic       less,
    input  logic [1:0] operation,
    input  logic       Ainvert,
    input  logic       Bnegate,
    output logic       res,
    output logic       cout,
    output logic       sum
);

    logic w_a;
    logic w_b;

    assign w_a  = ai ^ Ainvert;
    assign w_b  = bi ^ Bnegate;
    assign sum  = w_a ^ w_b ^ cin;
    assign cout = (w_a & w_b) | (w_a & cin) | (w_b & cin);

    always_comb begin
        res = 1'b0;
        case (operation)
            c_op_and: res = w_a & w_b;
            c_op_or:  res = w_a | w_b;
            c_op_add: res = sum;
            default:  res = less;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ula_serial.sv
// ============================================================================
// Module   : ula_serial
// Purpose  : Bit-serial WIDTH-bit ALU, LSB first, one bit per clock.
//            Optional macro ULA_OP_COUNT_EN adds a 16-bit completed-op counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_serial
    import ula_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    ula_serial_if.slave bus
`ifdef ULA_OP_COUNT_EN
    ,
    output logic [15:0] op_count
`endif
);

    localparam logic [CNTW-1:0] c_last_idx = CNTW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_ctl;
    logic             r_carry;
    logic [CNTW-1:0]  r_idx;
    logic [WIDTH-1:0] r_res;
    logic             r_msb_sum;
    logic             r_ovf;
    logic             r_cout;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_carry_out;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_res;
    logic             w_cout;
    logic             w_sum;
    logic [WIDTH-1:0] w_fix_res;
    logic             w_last;

    // Operands shift right each RUN cycle so the cell always sees bit 0.
    ula_bit_cell u_cell (
        .ai        (r_a[0]),
        .bi        (r_b[0]),
        .cin       (r_carry),
        .less      (1'b0),
        .operation (ctl_op(r_ctl)),
        .Ainvert   (r_ctl[c_ctl_ainv]),
        .Bnegate   (r_ctl[c_ctl_bneg]),
        .res       (w_res),
        .cout      (w_cout),
        .sum       (w_sum)
    );

    assign w_last = (r_idx == c_last_idx);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)       w_state_next = ST_FIX;
            ST_FIX:                    w_state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_next = ST_IDLE;
            default:                   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == ST_IDLE);
            r_out_valid <= (w_state_next == ST_DONE);
        end
    end

    // SLT: bit 0 was written as 0 during RUN; the sign of a-b, corrected
    // for overflow, is patched in here.
    always_comb begin
        w_fix_res = r_res;
        if (ctl_op(r_ctl) == c_op_slt) begin
            w_fix_res[0] = r_msb_sum ^ r_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_ctl       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_res       <= '0;
            r_msb_sum   <= 1'b0;
            r_ovf       <= 1'b0;
            r_cout      <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_ctl   <= bus.alu_ctl;
                        r_carry <= bus.alu_ctl[c_ctl_bneg];
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= {w_res, r_res[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_idx   <= r_idx + CNTW'(1);
                    if (w_last) begin
                        r_msb_sum <= w_sum;
                        r_ovf     <= r_carry ^ w_cout;
                        r_cout    <= w_cout;
                    end
                end
                ST_FIX: begin
                    r_result    <= w_fix_res;
                    r_zero      <= ~|w_fix_res;
                    r_overflow  <= (ctl_op(r_ctl) == c_op_add) & r_ovf;
                    r_carry_out <= (ctl_op(r_ctl) == c_op_add) & r_cout;
                end
                default: ;
            endcase
        end
    end

`ifdef ULA_OP_COUNT_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (r_out_valid && bus.out_ready) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_overflow;
    assign bus.carry_out = r_carry_out;

endmodule

`default_nettype wire

// File: tb/tb_ula_serial.sv
// ============================================================================
// Module   : tb_ula_serial
// Purpose  : Scoreboard bench for ula_serial (WIDTH=32), incl. latency,
//            backpressure and mid-operation reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ula_serial;
    import ula_pkg::*;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             ov;
        logic             co;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    exp_t q[$];
    exp_t mon_e;
`ifdef ULA_OP_COUNT_EN
    logic [15:0] op_count;
`endif

    ula_serial_if #(.WIDTH(WIDTH)) bus ();

    ula_serial #(.WIDTH(WIDTH), .CNTW(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef ULA_OP_COUNT_EN
        ,
        .op_count (op_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference computed at word level, independent of the serial datapath.
    function automatic exp_t model(input logic [3:0] ctl, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        logic [WIDTH-1:0] ai;
        logic [WIDTH-1:0] bi;
        logic [WIDTH:0]   s;
        logic             cmsb;
        logic             ovf;
        exp_t             e;
        ai   = ctl[3] ? ~av : av;
        bi   = ctl[2] ? ~bv : bv;
        s    = {1'b0, ai} + {1'b0, bi} + (WIDTH+1)'(ctl[2]);
        cmsb = s[WIDTH-1] ^ ai[WIDTH-1] ^ bi[WIDTH-1];
        ovf  = cmsb ^ s[WIDTH];
        case (ctl[1:0])
            2'b00:   e.res = ai & bi;
            2'b01:   e.res = ai | bi;
            2'b10:   e.res = s[WIDTH-1:0];
            default: e.res = {{(WIDTH-1){1'b0}}, s[WIDTH-1] ^ ovf};
        endcase
        e.z  = (e.res == '0);
        e.ov = (ctl[1:0] == 2'b10) & ovf;
        e.co = (ctl[1:0] == 2'b10) & s[WIDTH];
        return e;
    endfunction

    // Scoreboard: compare at the negedge preceding each output handshake.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_empty: got result=%h with no expected entry", bus.result);
            end else begin
                mon_e = q.pop_front();
                if ({bus.result, bus.zero, bus.overflow, bus.carry_out} !== mon_e) begin
                    n_err++;
                    $display("FAIL scoreboard: got res=%h z=%b ov=%b co=%b, expected res=%h z=%b ov=%b co=%b",
                             bus.result, bus.zero, bus.overflow, bus.carry_out,
                             mon_e.res, mon_e.z, mon_e.ov, mon_e.co);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] ctl, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit push);
        int n;
        if (push) q.push_back(model(ctl, av, bv));
        bus.alu_ctl  = ctl;
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        accept_cyc   = cyc;
        if (n >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] ctl, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        int lat;
        issue(ctl, av, bv, 1'b1);
        wait_out(lat);
        n_cmp++;
        if (lat !== 33) begin
            n_err++;
            $display("FAIL latency ctl=%b: got %0d edges, required 33", ctl, lat);
        end
        take();
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.overflow, bus.carry_out} !==
            {1'b1, 1'b0, {WIDTH{1'b0}}, 3'b000}) begin
            n_err++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b result=%h flags=%b%b%b, required 1 0 0 000",
                     bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.overflow, bus.carry_out);
        end
`ifdef ULA_OP_COUNT_EN
        n_cmp++;
        if (op_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_op_count: got %0d, required 0", op_count);
        end
`endif
    endtask

    task automatic test_add();
        run_op(ULA_ADD, 32'd5, 32'd7);
        run_op(ULA_ADD, 32'hFFFF_FFFF, 32'd1);
        run_op(ULA_ADD, 32'h7FFF_FFFF, 32'd1);
    endtask

    task automatic test_sub();
        run_op(ULA_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        run_op(ULA_SUB, 32'h0000_1234, 32'h0000_1234);
    endtask

    task automatic test_slt();
        run_op(ULA_SLT, 32'hFFFF_FFFD, 32'd2);
        run_op(ULA_SLT, 32'd2, 32'hFFFF_FFFD);
        run_op(ULA_SLT, 32'h8000_0000, 32'd1);
    endtask

    task automatic test_logic();
        run_op(ULA_NOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        run_op(ULA_OR,  32'hF0F0_F0F0, 32'h0F0F_0F0F);
        run_op(ULA_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
        for (int i = 0; i < 6; i++) begin
            run_op(4'($urandom_range(0, 15)), $urandom, $urandom);
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t held;
        issue(ULA_SUB, 32'd100, 32'd58, 1'b1);
        wait_out(lat);
        held = q[0];
        bus.a        = 32'd3;
        bus.b        = 32'd4;
        bus.alu_ctl  = ULA_ADD;
        bus.in_valid = 1'b1;
        q.push_back(model(ULA_ADD, 32'd3, 32'd4));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== held.res) begin
                n_err++;
                $display("FAIL backpressure_hold[%0d]: got in_ready=%b out_valid=%b result=%h, required 0 1 %h",
                         i, bus.in_ready, bus.out_valid, bus.result, held.res);
            end
        end
        take();
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_release: got in_ready=%b out_valid=%b, required 1 0",
                     bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_accept: got in_ready=%b, required 0", bus.in_ready);
        end
        wait_out(lat);
        n_cmp++;
        if (lat !== 33) begin
            n_err++;
            $display("FAIL backpressure_latency: got %0d edges, required 33", lat);
        end
        take();
    endtask

    task automatic test_back_to_back();
        int lat;
        int prev;
        issue(ULA_ADD, 32'd10, 32'd20, 1'b1);
        for (int i = 0; i < 4; i++) begin
            prev = accept_cyc;
            wait_out(lat);
            take();
            issue(ULA_SUB, $urandom, $urandom, 1'b1);
            n_cmp++;
            if (accept_cyc - prev !== WIDTH + 3) begin
                n_err++;
                $display("FAIL back_to_back_interval[%0d]: got %0d cycles, required %0d",
                         i, accept_cyc - prev, WIDTH + 3);
            end
        end
        wait_out(lat);
        take();
    endtask

    task automatic test_reset_midrun();
        issue(ULA_ADD, 32'h1234_5678, 32'h1, 1'b0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: got out_valid=%b in_ready=%b result=%h, required 0 1 0",
                     bus.out_valid, bus.in_ready, bus.result);
        end
`ifdef ULA_OP_COUNT_EN
        n_cmp++;
        if (op_count !== 16'd0) begin
            n_err++;
            $display("FAIL midrun_op_count_reset: got %0d, required 0", op_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(ULA_ADD, 32'd1, 32'd1);
`ifdef ULA_OP_COUNT_EN
        n_cmp++;
        if (op_count !== 16'd1) begin
            n_err++;
            $display("FAIL midrun_op_count_after: got %0d, required 1", op_count);
        end
`endif
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_ctl   = '0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_backpressure();
        test_back_to_back();
        test_reset_midrun();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d pending results, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
